// File: rtl/periph_pkg.sv
// Shared peripheral-block definitions: UART TX scheduler states, register
// addresses, and a counter-sizing helper.
package periph_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PULSE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } tx_sched_state_t;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  // Width of a counter that must reach the larger of two terminal counts.
  function automatic int ctr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) begin
      m = 1;
    end else begin
      m = m;
    end
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; the popped word is
// registered and held on rdata_o until the next pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rdata_o   = rdata_q;
  // Flush drops a coincident push but lets a coincident pop read the old head.
  assign push_ok_s = push_i && !full_o && !flush_i;
  assign pop_ok_s  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdata_d  = rdata_q;
    if (pop_ok_s) begin
      rdata_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      level_d  = level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Drains queued CPU bytes to the UART transmitter one frame at a time, with
// busy-rise timeout detection and sticky overflow/error status.
module uart_tx_scheduler
  import periph_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 15,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                       sysclk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic                       uart_tx_busy,
  output logic [7:0]                 uart_tx_data,
  output logic                       uart_tx_enable,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       idle,
  output logic                       overflow,
  output logic                       tx_err
);

  localparam int CW = ctr_width(BUSY_TIMEOUT, GAP_CYCLES);
  localparam tx_sched_state_t FRAME_END_ST = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  tx_sched_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            enable_q, enable_d;
  logic            overflow_q, overflow_d;
  logic            tx_err_q, tx_err_d;
  logic            pop_s;
  logic            err_set_s;
  logic            full_s;
  logic            empty_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (sysclk),
    .rst_i   (reset),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop_s),
    .flush_i (flush),
    .rdata_o (uart_tx_data),
    .level_o (level),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign full           = full_s;
  assign empty          = empty_s;
  assign idle           = empty_s && (state_q == ST_IDLE);
  assign uart_tx_enable = enable_q;
  assign overflow       = overflow_q;
  assign tx_err         = tx_err_q;

  // The pop is issued on the IDLE->LOAD edge so the head is registered and
  // stable on uart_tx_data for the whole of LOAD and PULSE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enable_d  = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        enable_d = 1'b1;
        state_d  = ST_PULSE;
      end
      ST_PULSE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q + CW'(1) == CW'(BUSY_TIMEOUT)) begin
          err_set_s = 1'b1;
          cnt_d     = '0;
          state_d   = FRAME_END_ST;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          cnt_d   = '0;
          state_d = FRAME_END_ST;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        if (cnt_q + CW'(1) == CW'(GAP_CYCLES)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky flags: a set event beats a simultaneous clear; flush suppresses overflow.
  always_comb begin
    overflow_d = overflow_q;
    tx_err_d   = tx_err_q;
    if (wr_en && full_s && !flush) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (err_set_s) begin
      tx_err_d = 1'b1;
    end else if (clr_err) begin
      tx_err_d = 1'b0;
    end else begin
      tx_err_d = tx_err_q;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      tx_err_q   <= tx_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios with randomized data and
// UART timing, checked every cycle against a queue/event-time model.
module tb_uart_tx_scheduler;

  localparam int DEPTH = 16;
  localparam int T     = 15;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          sysclk = 1'b0;
  logic          reset, wr_en, flush, clr_err, uart_tx_busy;
  logic [7:0]    wr_data;
  logic [7:0]    data0, data1;
  logic          en0, en1, full0, full1, empty0, empty1, idle0, idle1;
  logic          ovf0, ovf1, err0, err1;
  logic [LW-1:0] lvl0, lvl1;
  logic          sel = 1'b0;

  logic [7:0]    o_data;
  logic [LW-1:0] o_lvl;
  logic          o_en, o_full, o_empty, o_idle, o_ovf, o_err;

  always #5 sysclk = ~sysclk;

  uart_tx_scheduler #(.DEPTH(DEPTH), .BUSY_TIMEOUT(T), .GAP_CYCLES(0)) dut (
    .sysclk(sysclk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .clr_err(clr_err), .uart_tx_busy(uart_tx_busy),
    .uart_tx_data(data0), .uart_tx_enable(en0), .level(lvl0), .full(full0),
    .empty(empty0), .idle(idle0), .overflow(ovf0), .tx_err(err0)
  );

  uart_tx_scheduler #(.DEPTH(DEPTH), .BUSY_TIMEOUT(T), .GAP_CYCLES(3)) dut_gap (
    .sysclk(sysclk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .clr_err(clr_err), .uart_tx_busy(uart_tx_busy),
    .uart_tx_data(data1), .uart_tx_enable(en1), .level(lvl1), .full(full1),
    .empty(empty1), .idle(idle1), .overflow(ovf1), .tx_err(err1)
  );

  assign o_data  = sel ? data1  : data0;
  assign o_lvl   = sel ? lvl1   : lvl0;
  assign o_en    = sel ? en1    : en0;
  assign o_full  = sel ? full1  : full0;
  assign o_empty = sel ? empty1 : empty0;
  assign o_idle  = sel ? idle1  : idle0;
  assign o_ovf   = sel ? ovf1   : ovf0;
  assign o_err   = sel ? err1   : err0;

  // Reference model: byte queue plus absolute cycle numbers of upcoming events.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_data = 8'h00;
  int c = 0, ready = 0, en_cycle = -1, err_cycle = -1;
  int bs = -1, be = -2, gap = 0;
  int nd = 0, nl = 0, to_pct = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at cycle %0d", tag, obs, exp, c);
    end
  endtask

  task automatic check_all();
    chk("enable",   32'(o_en),    32'(c == en_cycle));
    chk("data",     32'(o_data),  32'(m_data));
    chk("level",    32'(o_lvl),   32'(q.size()));
    chk("full",     32'(o_full),  32'(q.size() == DEPTH));
    chk("empty",    32'(o_empty), 32'(q.size() == 0));
    chk("idle",     32'(o_idle),  32'(q.size() == 0 && c >= ready));
    chk("overflow", 32'(o_ovf),   32'(m_ovf));
    chk("tx_err",   32'(o_err),   32'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model to the next cycle, then check.
  task automatic step(input logic we, input logic [7:0] wd, input logic fl,
                      input logic ce, input logic rs);
    logic full_pre, err_set, ovf_set;
    int e, d, l;
    wr_en = we; wr_data = wd; flush = fl; clr_err = ce; reset = rs;
    uart_tx_busy = (c >= bs && c <= be);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0; m_err = 1'b0; m_data = 8'h00;
      ready = c + 1; en_cycle = -1; err_cycle = -1;
    end else begin
      full_pre = (q.size() == DEPTH);
      err_set  = (c == err_cycle);
      ovf_set  = we && !fl && full_pre;
      if (c >= ready && q.size() > 0) begin
        m_data = q.pop_front();
        e = c + 2;
        en_cycle = e;
        if (nd != 0) d = nd;
        else if (int'($urandom_range(0, 99)) < to_pct) d = T + 5;
        else d = int'($urandom_range(1, T));
        l = (nl != 0) ? nl : int'($urandom_range(1, 8));
        nd = 0; nl = 0;
        if (d <= T) begin
          bs = e + d; be = e + d + l - 1;
          ready = e + d + l + 1 + gap;
        end else begin
          err_cycle = e + T;
          ready = e + T + 1 + gap;
        end
      end
      if (fl) q.delete();
      else if (we && !full_pre) q.push_back(wd);
      m_ovf = ovf_set ? 1'b1 : (ce ? 1'b0 : m_ovf);
      m_err = err_set ? 1'b1 : (ce ? 1'b0 : m_err);
    end
    @(posedge sysclk);
    c++;
    #1;
    check_all();
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(q.size() == 0 && c >= ready && c > be) && n < budget) begin
      idle_step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL drain_budget observed %0d expected <%0d", n, budget);
    end
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!(c >= bs && c <= be) && n < budget) begin
      idle_step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL wait_busy observed %0d expected <%0d", n, budget);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Single byte: busy rises 2 cycles after enable and lasts 20 cycles.
    while (c < 9) idle_step();
    nd = 2; nl = 20;
    push(8'h55);
    drain(200);

    // Sixteen back-to-back pushes, sent in order.
    for (int i = 1; i <= 16; i++) push(8'(i));
    drain(2000);

    // Busy at the first and last accepted cycles.
    nd = 1; nl = 3; push(8'hC1);
    drain(200);
    nd = T; nl = 2; push(8'hC2);
    drain(200);

    // Overflow while the first frame is busy; set wins over clear.
    nl = 40;
    push(8'h3C);
    wait_busy(100);
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    repeat (3) idle_step();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drain(2000);

    // UART never asserts busy for the first byte.
    nd = 100;
    push(8'h11);
    push(8'h22);
    drain(400);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Flush during the first frame of five, with a push in the flush cycle.
    nl = 30;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    wait_busy(100);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    drain(400);
    repeat (5) idle_step();

    // Random traffic, occasional flush/clear and busy timeouts.
    to_pct = 10;
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 99)) < 35, 8'($urandom),
           int'($urandom_range(0, 99)) < 2, int'($urandom_range(0, 99)) < 4, 1'b0);
    end
    to_pct = 0;
    drain(4000);

    // Switch to the GAP_CYCLES=3 instance.
    sel = 1'b1;
    gap = 3;
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    nd = 2; nl = 5;
    push(8'hA1);
    push(8'hA2);
    drain(400);

    // Reset while WAIT_DONE; UART keeps its own frame going.
    nd = 2; nl = 20;
    push(8'hB1);
    push(8'hB2);
    wait_busy(100);
    repeat (3) idle_step();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Transmit-side controller for the peripheral block's UART. CPU bytes written to the UART TX data register are buffered in a FIFO; the block drains them one frame at a time, issuing a single-cycle enable to the UART transmitter and waiting for each frame to finish before starting the next. It sits between the peripheral bus write decode for 0x40000018 and the UART transmitter, and exports status bits for the UART_CON register.

## Interface
- `DEPTH`, 16: FIFO entries, power of two, ≥2.
- `BUSY_TIMEOUT`, 15: cycles to wait for `uart_tx_busy` to rise after an enable pulse.
- `GAP_CYCLES`, 0: idle cycles inserted between frames.
- `sysclk`  in  1  block clock, same clock as the UART.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push strobe, decoded bus write to 0x40000018.
- `wr_data`  in  8  byte to push.
- `flush`  in  1  discard all queued bytes; does not abort the frame in flight.
- `clr_err`  in  1  clear the sticky `overflow` and `tx_err` flags.
- `uart_tx_busy`  in  1  UART transmitter shifting a frame.
- `uart_tx_data`  out  8  byte presented to the UART.
- `uart_tx_enable`  out  1  one-cycle start pulse.
- `level`  out  $clog2(DEPTH+1)  queued byte count.
- `full`  out  1  `level == DEPTH`.
- `empty`  out  1  `level == 0`.
- `idle`  out  1  FIFO empty and FSM in IDLE.
- `overflow`  out  1  sticky: a push was dropped.
- `tx_err`  out  1  sticky: busy-rise timeout.

## Operation
- States: IDLE, LOAD, PULSE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if `!empty`, go to LOAD.
- LOAD: pop the FIFO head into `uart_tx_data`, then go to PULSE.
- PULSE: `uart_tx_enable`=1 for exactly this cycle, with `uart_tx_data` already stable. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - `uart_tx_busy`=1 → WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`, set `tx_err` and go to GAP; the byte is lost and is not retried.
- WAIT_DONE: `uart_tx_busy`=0 → GAP.
- GAP: stay `GAP_CYCLES` cycles, then go to IDLE. With `GAP_CYCLES`=0, go straight to IDLE.
- Push rules:
  - `wr_en` with `!full` enqueues.
  - `wr_en` with `full` drops the byte and sets `overflow`, even if LOAD pops in the same cycle (`full` is the registered value).
  - Push and pop in the same cycle: `level` is unchanged and both take effect.
- Flush:
  - `flush` zeroes the FIFO pointers and `level`. It wins over a simultaneous `wr_en`; that byte is dropped and `overflow` is not set.
  - A LOAD in the flush cycle still completes with the current head.
- Error flags: `clr_err` clears both flags. If a set event occurs in the same cycle, set wins.
- Pointers wrap modulo `DEPTH`. `level` ranges 0..`DEPTH`.
- `uart_tx_data` holds the last sent byte until the next LOAD.

## Timing
- Reset values: FSM in IDLE, `level`=0, `empty`=1, `full`=0, `idle`=1. `uart_tx_data`=0, `uart_tx_enable`=0, `overflow`=0, `tx_err`=0.
- Push at edge N into an empty idle FIFO:
  - `empty` falls after N.
  - LOAD is at N+1, `uart_tx_enable` is high in cycle N+2, `level` returns to 0 after N+1.
- Busy rise: accepted on any cycle from PULSE+1 up to PULSE+`BUSY_TIMEOUT`.
- Frame-to-frame spacing: the next enable comes 3+`GAP_CYCLES` cycles after the busy fall is sampled.
- Reset mid-frame: FIFO is emptied and `uart_tx_enable` is low next cycle. The UART's own frame is not affected.
- All outputs are registered except `full`, `empty` and `idle`, which decode registered state.

## Structure
- Shared package `periph_pkg`:
  - FSM state enum `tx_sched_state_t`.
  - Peripheral address constants: `UART_TXD_ADDR`=0x40000018, `UART_RXD_ADDR`=0x4000001C, `UART_CON_ADDR`=0x40000020.
- Sub-module `sync_fifo`:
  - Parameterized width and depth; push, pop, flush, level.
  - First-word data is registered on pop.
  - Reused later for the RX path.

## Test plan
- Reset, then push 0x55 at cycle 10, with the UART model asserting busy for 20 cycles starting 2 cycles after enable → enable pulse in cycle 12 with `uart_tx_data`=0x55; `idle` returns after busy falls.
- Push 0x01..0x10 back-to-back (`DEPTH`=16) → all 16 accepted, `overflow`=0. Bytes are sent in order, each enable after the previous busy fall; no pulse is ever longer than one cycle.
- Fill to 16 while the first frame is busy, then push 0xAA → `overflow`=1, 0xAA never transmitted, `level` stays 16. `clr_err` clears the flag.
- UART model never asserts busy → `tx_err`=1 exactly `BUSY_TIMEOUT` cycles after the pulse, FSM advances, next queued byte is sent.
- Queue 5 bytes, assert `flush` during the first frame's busy → that frame completes; `level`=0 and no further enables. A `wr_en` in the flush cycle is dropped.
- `GAP_CYCLES`=3 with two bytes → second enable comes 6 cycles after the busy fall. Assert `reset` mid-WAIT_DONE → all outputs return to reset values next cycle.
